// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: active-low glyph
// patterns (bit order g..a), the all-off segment word and the scan FSM states.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h40;
    localparam logic [6:0] GLYPH_1 = 7'h79;
    localparam logic [6:0] GLYPH_2 = 7'h24;
    localparam logic [6:0] GLYPH_3 = 7'h30;
    localparam logic [6:0] GLYPH_4 = 7'h19;
    localparam logic [6:0] GLYPH_5 = 7'h12;
    localparam logic [6:0] GLYPH_6 = 7'h02;
    localparam logic [6:0] GLYPH_7 = 7'h78;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h10;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h03;
    localparam logic [6:0] GLYPH_C = 7'h46;
    localparam logic [6:0] GLYPH_D = 7'h21;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_F = 7'h0E;

    // Segment pattern for a digit that is selected but shows nothing.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Full segment word (dp included) with everything dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph decoder; A..F decode to hex letters.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    // Map every nibble value to its active-low segment pattern.
    always_comb begin
        seg_n = GLYPH_0;
        unique case (nibble)
            4'h0: seg_n = GLYPH_0;
            4'h1: seg_n = GLYPH_1;
            4'h2: seg_n = GLYPH_2;
            4'h3: seg_n = GLYPH_3;
            4'h4: seg_n = GLYPH_4;
            4'h5: seg_n = GLYPH_5;
            4'h6: seg_n = GLYPH_6;
            4'h7: seg_n = GLYPH_7;
            4'h8: seg_n = GLYPH_8;
            4'h9: seg_n = GLYPH_9;
            4'hA: seg_n = GLYPH_A;
            4'hB: seg_n = GLYPH_B;
            4'hC: seg_n = GLYPH_C;
            4'hD: seg_n = GLYPH_D;
            4'hE: seg_n = GLYPH_E;
            4'hF: seg_n = GLYPH_F;
            default: seg_n = GLYPH_0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Each digit slot starts
// with a dark gap to avoid ghosting; the displayed value is frozen per frame
// in snapshot registers so a frame never mixes old and new digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 4096,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_tick
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(PRESCALE - 1);
    localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);
    localparam logic [DIDX_W-1:0] DIDX_MAX  = DIDX_W'(DIGITS - 1);

    logic [PCNT_W-1:0]   pcnt;
    logic [DIDX_W-1:0]   didx;
    scan_state_t         state;

    logic [4*DIGITS-1:0] snap_bcd;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_blank_lz;

    logic [DIGITS-1:0]   lz_mask;
    logic                lz_all_zero;
    logic [3:0]          cur_nibble;
    logic [6:0]          glyph_n;
    logic [7:0]          seg_show;
    logic [DIGITS-1:0]   dig_show;
    logic                show_slot;
    logic                snap_point;

    assign snap_point = (pcnt == '0) && (didx == '0);
    assign show_slot  = enable && (pcnt >= BLANK_END);
    assign cur_nibble = snap_bcd[{didx, 2'b00} +: 4];

    seg7_glyph u_glyph (
        .nibble (cur_nibble),
        .seg_n  (glyph_n)
    );

    // Prescaler and digit index; disabling parks the scan at the frame start.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pcnt <= '0;
            didx <= '0;
        end else if (!enable) begin
            pcnt <= '0;
            didx <= '0;
        end else if (pcnt == PCNT_MAX) begin
            pcnt <= '0;
            didx <= (didx == DIDX_MAX) ? '0 : didx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Latch the inputs once per frame at the very first cycle of digit 0.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            snap_bcd      <= '0;
            snap_dp       <= '0;
            snap_blank_lz <= 1'b0;
        end else if (snap_point) begin
            snap_bcd      <= bcd_in;
            snap_dp       <= dp_in;
            snap_blank_lz <= blank_lz;
        end
    end

    // Digit i (i >= 1) is suppressed while it and every digit above it are zero.
    always_comb begin
        lz_mask     = '0;
        lz_all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_all_zero = lz_all_zero & (snap_bcd[i*4 +: 4] == 4'h0);
            lz_mask[i]  = snap_blank_lz & lz_all_zero;
        end
    end

    // Segment and digit-select words for the digit currently being scanned.
    always_comb begin
        dig_show       = '1;
        dig_show[didx] = 1'b0;
        seg_show       = {~snap_dp[didx], lz_mask[didx] ? SEG_BLANK : glyph_n};
    end

    // Scan FSM with registered outputs; segments and digit select move together.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ST_BLANK;
            seg_n      <= SEG_OFF;
            dig_n      <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= enable && (pcnt == PCNT_MAX) && (didx == DIDX_MAX);
            unique case (state)
                ST_BLANK: begin
                    if (show_slot) begin
                        state <= ST_SHOW;
                        seg_n <= seg_show;
                        dig_n <= dig_show;
                    end else begin
                        seg_n <= SEG_OFF;
                        dig_n <= '1;
                    end
                end
                ST_SHOW: begin
                    if (!show_slot) begin
                        state <= ST_BLANK;
                        seg_n <= SEG_OFF;
                        dig_n <= '1;
                    end else begin
                        seg_n <= seg_show;
                        dig_n <= dig_show;
                    end
                end
                default: begin
                    state <= ST_BLANK;
                    seg_n <= SEG_OFF;
                    dig_n <= '1;
                end
            endcase
        end
    end

endmodule
